// File: rtl/demux16_deser.sv
// Serial-to-parallel demux: steers one din bit per accepted beat into one of WIDTH registered lanes.
// Latency: an accepted beat is visible on dout/written/ptr one cycle after its edge; frame_valid follows the completing beat by one cycle.
// Backpressure: din_ready drops while a complete frame is held, while en is low, and while in reset; it is released by frame_ready or clear.
module demux16_deser #(
  parameter int WIDTH = 16,
  parameter int SEL_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             mode,
  input  logic [SEL_W-1:0] sel,
  input  logic             din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             clear,
  input  logic             frame_ready,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] written,
  output logic [SEL_W-1:0] ptr,
  output logic             frame_valid,
  output logic [7:0]       frame_count
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] written_q, written_d;
  logic [SEL_W-1:0] ptr_q, ptr_d;
  logic [7:0]       count_q, count_d;

  logic [SEL_W-1:0] addr;
  logic [WIDTH-1:0] lane_onehot;
  logic             accept;
  logic             completes;

  // Handshake and lane decode; din_valid only qualifies accept, never din_ready.
  always_comb begin
    din_ready   = rst_n & en & (state_q != HOLD);
    accept      = din_valid & din_ready & ~clear;
    addr        = mode ? ptr_q : sel;
    lane_onehot = '0;
    lane_onehot[addr] = 1'b1;
    // A rewrite of an already-written lane cannot complete: written only reaches
    // all ones via a new lane, since an all-ones mask implies HOLD (no accepts).
    completes   = accept & ~written_q[addr] & (&(written_q | lane_onehot));
  end

  // Next-state and datapath update; clear overrides accept and frame_ready.
  always_comb begin
    state_d   = state_q;
    dout_d    = dout_q;
    written_d = written_q;
    ptr_d     = ptr_q;
    count_d   = count_q;
    if (clear) begin
      state_d   = IDLE;
      written_d = '0;
      ptr_d     = '0;
    end else begin
      case (state_q)
        IDLE, FILL: begin
          if (accept) begin
            dout_d[addr] = din;
            written_d    = written_q | lane_onehot;
            if (mode) begin
              ptr_d = ptr_q + 1'b1;
            end
            if (completes) begin
              state_d = HOLD;
              count_d = count_q + 8'd1;
            end else begin
              state_d = FILL;
            end
          end
        end
        HOLD: begin
          if (frame_ready) begin
            state_d   = IDLE;
            written_d = '0;
            ptr_d     = '0;
          end
        end
        default: begin
          state_d   = IDLE;
          written_d = '0;
          ptr_d     = '0;
        end
      endcase
    end
  end

  // State and datapath registers; reset also wipes the held frame data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dout_q    <= '0;
      written_q <= '0;
      ptr_q     <= '0;
      count_q   <= '0;
    end else if (en || clear || frame_ready) begin
      state_q   <= state_d;
      dout_q    <= dout_d;
      written_q <= written_d;
      ptr_q     <= ptr_d;
      count_q   <= count_d;
    end
  end

  // Outputs come straight from registers.
  always_comb begin
    dout        = dout_q;
    written     = written_q;
    ptr         = ptr_q;
    frame_valid = (state_q == HOLD);
    frame_count = count_q;
  end

endmodule

// File: tb/tb_demux16_deser.sv
// Directed bench for demux16_deser with a frame scoreboard.
// Expected frames are queued as beats are driven and compared when frame_valid rises.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_demux16_deser;

  logic        clk = 1'b0;
  logic        rst_n, en, mode, din, din_valid, clear, frame_ready;
  logic [3:0]  sel;
  logic        din_ready, frame_valid;
  logic [15:0] dout, written;
  logic [3:0]  ptr;
  logic [7:0]  frame_count;

  typedef struct packed {
    logic [15:0] word;
    logic [7:0]  cnt;
  } frame_t;

  frame_t      sb_q[$];
  logic [15:0] m_dout, m_written;
  logic [3:0]  m_ptr;
  logic [7:0]  m_cnt;
  logic        fv_prev;
  int          n_assert = 0;
  int          n_fail   = 0;

  demux16_deser #(.WIDTH(16), .SEL_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .sel(sel), .din(din),
    .din_valid(din_valid), .din_ready(din_ready), .clear(clear),
    .frame_ready(frame_ready), .dout(dout), .written(written), .ptr(ptr),
    .frame_valid(frame_valid), .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle, then run the scoreboard monitor on a frame_valid rise.
  task automatic tick();
    frame_t f;
    @(posedge clk);
    #1;
    if (frame_valid === 1'b1 && fv_prev !== 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_frame", 32'(frame_valid), 32'd0);
      end else begin
        f = sb_q.pop_front();
        chk("sb_dout", 32'(dout), 32'(f.word));
        chk("sb_count", 32'(frame_count), 32'(f.cnt));
      end
    end
    fv_prev = frame_valid;
  endtask

  // One accepted beat; the model predicts lane, mask, pointer and completion.
  task automatic beat(input logic m, input logic [3:0] s, input logic b);
    logic [3:0] a;
    frame_t     f;
    mode = m; sel = s; din = b; din_valid = 1'b1;
    a = m ? m_ptr : s;
    m_dout[a] = b;
    if (!m_written[a]) begin
      m_written[a] = 1'b1;
      if (&m_written) begin
        m_cnt  = m_cnt + 8'd1;
        f.word = m_dout;
        f.cnt  = m_cnt;
        sb_q.push_back(f);
      end
    end
    if (m) m_ptr = m_ptr + 4'd1;
    tick();
    din_valid = 1'b0;
  endtask

  task automatic ack();
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    m_written = '0;
    m_ptr     = '0;
  endtask

  task automatic seq_frame(input logic [15:0] w);
    for (int i = 0; i < 16; i++) beat(1'b1, 4'd0, w[i]);
  endtask

  initial begin
    logic [15:0] w;
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; sel = '0; din = 1'b1;
    din_valid = 1'b1; clear = 1'b0; frame_ready = 1'b0;
    m_dout = '0; m_written = '0; m_ptr = '0; m_cnt = '0; fv_prev = 1'b0;

    // Reset with a beat offered
    #1;
    chk("rst_din_ready_a", 32'(din_ready), 32'd0);
    tick();
    chk("rst_din_ready_b", 32'(din_ready), 32'd0);
    tick();
    din_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("rst_dout", 32'(dout), 32'h0000);
    chk("rst_written", 32'(written), 32'h0000);
    chk("rst_count", 32'(frame_count), 32'd0);
    chk("rst_fv", 32'(frame_valid), 32'd0);
    chk("rst_ptr", 32'(ptr), 32'd0);
    chk("idle_din_ready", 32'(din_ready), 32'd1);

    // Sequential frame 0xA5C3
    w = 16'hA5C3;
    beat(1'b1, 4'd0, w[0]);
    chk("seq_first_written", 32'(written), 32'h0001);
    chk("seq_first_ptr", 32'(ptr), 32'd1);
    for (int i = 1; i < 16; i++) beat(1'b1, 4'd0, w[i]);
    chk("seq_dout", 32'(dout), 32'hA5C3);
    chk("seq_fv", 32'(frame_valid), 32'd1);
    chk("seq_din_ready", 32'(din_ready), 32'd0);
    chk("seq_count", 32'(frame_count), 32'd1);
    chk("seq_ptr", 32'(ptr), 32'd0);
    ack();
    chk("ack_fv", 32'(frame_valid), 32'd0);
    chk("ack_written", 32'(written), 32'h0000);
    chk("ack_din_ready", 32'(din_ready), 32'd1);
    chk("ack_dout_kept", 32'(dout), 32'hA5C3);

    // Addressed mode with a rewrite of lane 3
    beat(1'b0, 4'd3, 1'b1);
    chk("adr_l3_set", 32'(dout[3]), 32'd1);
    chk("adr_written_a", 32'(written), 32'h0008);
    beat(1'b0, 4'd3, 1'b0);
    chk("adr_l3_clr", 32'(dout[3]), 32'd0);
    chk("adr_written_b", 32'(written), 32'h0008);
    chk("adr_no_done", 32'(frame_valid), 32'd0);
    w = 16'h1234;
    for (int i = 0; i < 16; i++) begin
      if (i != 3) begin
        if (i == 15) chk("adr_fv_before_last", 32'(frame_valid), 32'd0);
        beat(1'b0, 4'(i), w[i]);
      end
    end
    chk("adr_fv_done", 32'(frame_valid), 32'd1);
    chk("adr_l3_final", 32'(dout[3]), 32'd0);
    chk("adr_dout", 32'(dout), 32'(m_dout));
    ack();

    // Stall with en low mid-frame
    w = 16'h5E71;
    for (int i = 0; i < 5; i++) beat(1'b1, 4'd0, w[i]);
    en = 1'b0; din_valid = 1'b1; din = ~w[5]; mode = 1'b1;
    #1;
    chk("stall_din_ready", 32'(din_ready), 32'd0);
    for (int i = 0; i < 3; i++) tick();
    din_valid = 1'b0;
    chk("stall_dout", 32'(dout), 32'(m_dout));
    chk("stall_written", 32'(written), 32'(m_written));
    chk("stall_ptr", 32'(ptr), 32'(m_ptr));
    en = 1'b1;
    for (int i = 5; i < 16; i++) beat(1'b1, 4'd0, w[i]);
    chk("stall_fv", 32'(frame_valid), 32'd1);
    chk("stall_count", 32'(frame_count), 32'(m_cnt));
    ack();

    // Clear with a beat offered during FILL
    w = 16'h0F0F;
    for (int i = 0; i < 7; i++) beat(1'b1, 4'd0, w[i]);
    chk("clr_pre_written", 32'(written), 32'h007F);
    clear = 1'b1; din_valid = 1'b1; mode = 1'b1; din = ~m_dout[7];
    tick();
    clear = 1'b0; din_valid = 1'b0;
    m_written = '0; m_ptr = '0;
    chk("clr_written", 32'(written), 32'h0000);
    chk("clr_ptr", 32'(ptr), 32'd0);
    chk("clr_fv", 32'(frame_valid), 32'd0);
    chk("clr_dout", 32'(dout), 32'(m_dout));
    chk("clr_count", 32'(frame_count), 32'(m_cnt));

    // Run frames until the counter wraps
    while (m_cnt != 8'd0) begin
      seq_frame(16'($urandom));
      ack();
    end
    chk("wrap_count", 32'(frame_count), 32'd0);

    // clear and frame_ready together in HOLD
    seq_frame(16'hBEEF);
    chk("prio_hold", 32'(frame_valid), 32'd1);
    clear = 1'b1; frame_ready = 1'b1;
    tick();
    clear = 1'b0; frame_ready = 1'b0;
    m_written = '0; m_ptr = '0;
    chk("prio_fv", 32'(frame_valid), 32'd0);
    chk("prio_count", 32'(frame_count), 32'd1);
    chk("prio_written", 32'(written), 32'h0000);
    chk("prio_din_ready", 32'(din_ready), 32'd1);
    chk("prio_dout", 32'(dout), 32'hBEEF);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
